// File: rtl/cnn_conv1_pkg.sv
// Shared constants and types for the conv1 convolution-sum scheduler.
// Image geometry, channel count, result width, FSM state encoding and channel-select type.
`timescale 1ns/1ps
package cnn_conv1_pkg;

   localparam int WIDTH         = 28;
   localparam int HEIGHT        = 28;
   localparam int FILTER_SIZE   = 5;
   localparam int CHANNEL_LEN   = 3;
   localparam int RES_BITS      = 12;
   localparam int OUT_PER_FRAME = (WIDTH - FILTER_SIZE + 1) * (HEIGHT - FILTER_SIZE + 1);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ISSUE   = 2'd1,
      ST_COLLECT = 2'd2,
      ST_HOLD    = 2'd3
   } sched_state_t;

   typedef logic [1:0] ch_sel_t;
   typedef logic signed [RES_BITS-1:0] res_t;

   function automatic res_t relu(input res_t v);
      return (v < 0) ? '0 : v;
   endfunction

endpackage

// File: rtl/conv1_beat_counter.sv
// Wrapping modulo-MODULO output-beat counter; wrap pulses combinationally on the
// increment that takes the count from MODULO-1 back to 0.
`timescale 1ns/1ps
module conv1_beat_counter #(
   parameter int MODULO = 576
) (
   input  logic clk,
   input  logic rst,
   input  logic inc,
   output logic wrap
);

   localparam int CW = $clog2(MODULO);

   logic [CW-1:0] count;

   assign wrap = inc && (count == CW'(MODULO - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         count <= '0;
      end else if (inc) begin
         count <= wrap ? '0 : count + 1'b1;
      end
   end

endmodule

// File: rtl/conv1_calc_sched.sv
// Conv1 MAC scheduler: one window in, CHANNEL_LEN MAC passes issued, results gathered into one beat.
// Optional build macro CONV1_SCHED_RELU_EN clamps negative results to zero as they are stored.
`timescale 1ns/1ps
module conv1_calc_sched
   import cnn_conv1_pkg::*;
(
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            win_valid,
   output logic                            win_ready,
   output logic                            calc_start,
   output logic [1:0]                      calc_ch_sel,
   input  logic                            calc_valid,
   input  logic signed [RES_BITS-1:0]      calc_result,
   output logic                            out_valid,
   input  logic                            out_ready,
   output logic [CHANNEL_LEN*RES_BITS-1:0] conv_out,
   output logic                            frame_done,
   output logic                            sched_err
);

   localparam ch_sel_t LAST_CH = ch_sel_t'(CHANNEL_LEN - 1);

   sched_state_t state;
   ch_sel_t      issue_cnt;
   ch_sel_t      collect_cnt;
   res_t         slot [CHANNEL_LEN];
   res_t         slot_wr;
   logic         collect_en;
   logic         out_fire;

   // Handshake signals derive from state alone so upstream never sees a combinational path from out_ready.
   assign win_ready  = (state == ST_IDLE);
   assign out_valid  = (state == ST_HOLD);
   assign out_fire   = out_valid && out_ready;
   assign collect_en = calc_valid && ((state == ST_ISSUE) || (state == ST_COLLECT));

`ifdef CONV1_SCHED_RELU_EN
   assign slot_wr = relu(calc_result);
`else
   assign slot_wr = calc_result;
`endif

   // NOTE: the result slots are reset like any other register because conv_out must read zero out of reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= ST_IDLE;
         issue_cnt   <= '0;
         collect_cnt <= '0;
         calc_start  <= 1'b0;
         calc_ch_sel <= '0;
         sched_err   <= 1'b0;
         for (int i = 0; i < CHANNEL_LEN; i++) slot[i] <= '0;
      end else begin
         if (calc_valid && ((state == ST_IDLE) || (state == ST_HOLD))) sched_err <= 1'b1;

         if (collect_en) begin
            for (int i = 0; i < CHANNEL_LEN; i++) begin
               if (collect_cnt == ch_sel_t'(i)) slot[i] <= slot_wr;
            end
            collect_cnt <= collect_cnt + 1'b1;
         end

         case (state)
            ST_IDLE: begin
               if (win_valid) begin
                  state       <= ST_ISSUE;
                  calc_start  <= 1'b1;
                  calc_ch_sel <= '0;
                  issue_cnt   <= '0;
               end
            end
            ST_ISSUE: begin
               if (issue_cnt == LAST_CH) begin
                  state       <= ST_COLLECT;
                  calc_start  <= 1'b0;
                  calc_ch_sel <= '0;
               end else begin
                  issue_cnt   <= issue_cnt + 1'b1;
                  calc_ch_sel <= issue_cnt + 1'b1;
               end
            end
            ST_COLLECT: begin
               // Overrides the increment above so the next window starts from slot 0.
               if (calc_valid && (collect_cnt == LAST_CH)) begin
                  state       <= ST_HOLD;
                  collect_cnt <= '0;
               end
            end
            ST_HOLD: begin
               if (out_ready) state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   always_comb begin
      conv_out = '0;
      for (int i = 0; i < CHANNEL_LEN; i++) conv_out[i*RES_BITS +: RES_BITS] = slot[i];
   end

   conv1_beat_counter #(
      .MODULO (OUT_PER_FRAME)
   ) u_beat_counter (
      .clk  (clk),
      .rst  (rst),
      .inc  (out_fire),
      .wrap (frame_done)
   );

endmodule

// File: tb/tb_conv1_calc_sched.sv
// Scoreboard bench for conv1_calc_sched: directed windows, a latency-1 MAC model and a beat monitor.
// Build with CONV1_SCHED_RELU_EN defined to check the clamped-result variant.
`timescale 1ns/1ps
module tb_conv1_calc_sched;
   import cnn_conv1_pkg::*;

   localparam int OW = CHANNEL_LEN * RES_BITS;

   logic                     clk = 1'b0;
   logic                     rst = 1'b1;
   logic                     win_valid = 1'b0;
   logic                     win_ready;
   logic                     calc_start;
   logic [1:0]               calc_ch_sel;
   logic                     calc_valid = 1'b0;
   logic signed [RES_BITS-1:0] calc_result = '0;
   logic                     out_valid;
   logic                     out_ready = 1'b1;
   logic [OW-1:0]            conv_out;
   logic                     frame_done;
   logic                     sched_err;

   conv1_calc_sched dut (
      .clk         (clk),
      .rst         (rst),
      .win_valid   (win_valid),
      .win_ready   (win_ready),
      .calc_start  (calc_start),
      .calc_ch_sel (calc_ch_sel),
      .calc_valid  (calc_valid),
      .calc_result (calc_result),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .conv_out    (conv_out),
      .frame_done  (frame_done),
      .sched_err   (sched_err)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [OW-1:0] pack3(input int a, input int b, input int c);
      logic [RES_BITS-1:0] ra, rb, rc;
      ra = RES_BITS'(a);
      rb = RES_BITS'(b);
      rc = RES_BITS'(c);
      return {rc, rb, ra};
   endfunction

   logic [OW-1:0] exp_q [$];

   // MAC model: answers each calc_start one cycle later, or replays manual values when disabled.
   logic mac_auto = 1'b1;
   logic man_valid = 1'b0;
   logic signed [RES_BITS-1:0] man_res = '0;
   int   mac_vals [3] = '{0, 0, 0};
   logic p_valid = 1'b0;
   logic signed [RES_BITS-1:0] p_res = '0;
   int   exp_sel = 0;
   int   start_total = 0;

   initial forever begin
      @(negedge clk);
      if (rst) begin
         p_valid    = 1'b0;
         exp_sel    = 0;
         calc_valid = mac_auto ? 1'b0 : man_valid;
      end else begin
         if (mac_auto) begin
            calc_valid  = p_valid;
            calc_result = p_res;
         end else begin
            calc_valid  = man_valid;
            calc_result = man_res;
         end
         p_valid = calc_start && mac_auto;
         if (calc_start) begin
            start_total++;
            check("calc_ch_sel", 64'(calc_ch_sel), 64'(exp_sel));
            p_res   = RES_BITS'(mac_vals[calc_ch_sel]);
            exp_sel = (exp_sel + 1) % CHANNEL_LEN;
         end
      end
   end

   // Output monitor: pops the scoreboard on every handshake and tracks the frame position.
   int tb_beats     = 0;
   int frame_pulses = 0;

   initial forever begin
      logic [OW-1:0] exp_v;
      @(negedge clk);
      if (rst) begin
         exp_q.delete();
         tb_beats = 0;
      end else begin
         if (frame_done) frame_pulses++;
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               check("spurious_out_beat", 64'(out_valid), 64'(0));
            end else begin
               exp_v = exp_q.pop_front();
               check("conv_out", 64'(conv_out), 64'(exp_v));
            end
            check("frame_done_on_beat", 64'(frame_done), 64'(tb_beats == OUT_PER_FRAME - 1));
            tb_beats = (tb_beats + 1) % OUT_PER_FRAME;
         end else if (frame_done) begin
            check("frame_done_stray", 64'(frame_done), 64'(0));
         end
      end
   end

   int windows_sent = 0;

   task automatic send_window(input int a, input int b, input int c, input logic [OW-1:0] exp_v);
      int t = 0;
      @(negedge clk);
      while (!win_ready && t < 100) begin
         @(negedge clk);
         t++;
      end
      if (!win_ready) begin
         check("win_ready_timeout", 64'(win_ready), 64'(1));
      end else begin
         mac_vals = '{a, b, c};
         exp_q.push_back(exp_v);
         windows_sent++;
         win_valid = 1'b1;
         @(posedge clk);
         #1 win_valid = 1'b0;
      end
   endtask

   task automatic wait_idle();
      int t = 0;
      @(negedge clk);
      while (!(win_ready && exp_q.size() == 0) && t < 200) begin
         @(negedge clk);
         t++;
      end
      check("idle_timeout", 64'(exp_q.size()), 64'(0));
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int t;
      int frame_base;
      logic [OW-1:0] bp_exp;

      // Reset then idle
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("rst_win_ready",   64'(win_ready),   64'(1));
      check("rst_out_valid",   64'(out_valid),   64'(0));
      check("rst_calc_start",  64'(calc_start),  64'(0));
      check("rst_calc_ch_sel", 64'(calc_ch_sel), 64'(0));
      check("rst_sched_err",   64'(sched_err),   64'(0));
      check("rst_conv_out",    64'(conv_out),    64'(0));
      check("rst_frame_done",  64'(frame_done),  64'(0));

      // Single window: {2047,-5,100}
      send_window(100, -5, 2047, 36'h7FF_FFB_064);
      wait_idle();
      check("win_ready_after_beat", 64'(win_ready), 64'(1));

      // Backpressure: HOLD for 10 cycles with win_valid asserted
      @(posedge clk);
      #1 out_ready = 1'b0;
      bp_exp = 36'h003_002_001;
      send_window(1, 2, 3, bp_exp);
      t = 0;
      @(negedge clk);
      while (!out_valid && t < 50) begin
         @(negedge clk);
         t++;
      end
      check("bp_out_valid", 64'(out_valid), 64'(1));
      win_valid = 1'b1;
      repeat (10) begin
         @(negedge clk);
         check("bp_conv_out",   64'(conv_out),   64'(bp_exp));
         check("bp_win_ready",  64'(win_ready),  64'(0));
         check("bp_calc_start", 64'(calc_start), 64'(0));
      end
      win_valid = 1'b0;
      @(posedge clk);
      #1 out_ready = 1'b1;
      wait_idle();

      // Spurious calc_valid in IDLE
      @(posedge clk);
      #1 mac_auto = 1'b0;
      man_valid = 1'b1;
      man_res   = 12'sd123;
      @(posedge clk);
      #1 man_valid = 1'b0;
      @(negedge clk);
      check("spur_sched_err", 64'(sched_err), 64'(1));
      check("spur_win_ready", 64'(win_ready), 64'(1));
      check("spur_out_valid", 64'(out_valid), 64'(0));
      repeat (5) @(negedge clk);
      check("spur_sched_err_sticky", 64'(sched_err), 64'(1));
      @(posedge clk);
      #1 mac_auto = 1'b1;
      send_window(512, 0, 1, 36'h001_000_200);
      wait_idle();
      check("spur_sched_err_after_win", 64'(sched_err), 64'(1));

      // Reset during COLLECT after one result
      @(posedge clk);
      #1 mac_auto = 1'b0;
      send_window(9, 9, 9, 36'h009_009_009);
      t = 0;
      @(negedge clk);
      while (!calc_start && t < 20) begin
         @(negedge clk);
         t++;
      end
      while (calc_start && t < 40) begin
         @(negedge clk);
         t++;
      end
      check("rstmid_in_collect", 64'(calc_start), 64'(0));
      @(posedge clk);
      #1 man_valid = 1'b1;
      man_res = 12'sd77;
      @(posedge clk);
      #1 man_valid = 1'b0;
      @(posedge clk);
      #1 rst = 1'b1;
      @(negedge clk);
      @(negedge clk);
      check("rstmid_win_ready",  64'(win_ready),  64'(1));
      check("rstmid_out_valid",  64'(out_valid),  64'(0));
      check("rstmid_calc_start", 64'(calc_start), 64'(0));
      check("rstmid_sched_err",  64'(sched_err),  64'(0));
      check("rstmid_frame_done", 64'(frame_done), 64'(0));
      @(posedge clk);
      #1 rst = 1'b0;
      mac_auto = 1'b1;
      send_window(300, 400, 500, 36'h1F4_190_12C);
      wait_idle();

      // Clamp behaviour depends on the build
`ifdef CONV1_SCHED_RELU_EN
      send_window(-1, 0, 7, 36'h007_000_000);
`else
      send_window(-1, 0, 7, 36'h007_000_FFF);
`endif
      wait_idle();

      // Full frame from a clean counter, then one beat into the next frame
      @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      frame_base = frame_pulses;
      for (int i = 0; i < OUT_PER_FRAME; i++) begin
         send_window(i % 100, 1, 2, pack3(i % 100, 1, 2));
      end
      wait_idle();
      check("frame_done_count", 64'(frame_pulses - frame_base), 64'(1));
      send_window(7, 8, 9, 36'h009_008_007);
      wait_idle();
      check("frame_done_next_frame", 64'(frame_pulses - frame_base), 64'(1));

      check("calc_start_cycles", 64'(start_total), 64'(CHANNEL_LEN * windows_sent));
      check("scoreboard_drained", 64'(exp_q.size()), 64'(0));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
